lsu: RTL and testbench



---
 rtl/rv32i_pkg.sv | 30 +++
 rtl/lsu_if.sv | 47 ++++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu.sv | 214 +++++++++++++++++++++
 tb/tb_lsu.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants used by the load/store unit: opcodes, funct3
// width encodings, mcause codes and the LSU state encoding.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// LSU signal bundle: execute-stage request, data-memory bus and writeback
// response. The master side is the environment (execute stage plus memory),
// the slave side is the LSU itself.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  logic        rsp_valid;
  logic        rsp_we;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_exc;
  logic [3:0]  rsp_cause;

  modport master (
    output req_valid, req_opcode, req_funct3, req_addr, req_wdata, req_rd,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_we, rsp_rd, rsp_data, rsp_exc, rsp_cause
  );

  modport slave (
    input  req_valid, req_opcode, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_we, rsp_rd, rsp_data, rsp_exc, rsp_cause
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and lane replication,
// and load extraction with sign/zero extension. Purely combinational.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // byte enables and store-data replication; size comes from funct3[1:0]
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_in;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  // load extraction and extension from the shifted word
  always_comb begin
    rdata_ext = shifted;
    case (funct3)
      F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  rdata_ext = {24'h0, shifted[7:0]};
      F3_LHU:  rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one memory transaction at a time over a
// valid/grant/rvalid bus, with alignment checks, a REQ+WAIT timeout and a
// single-cycle registered response to writeback.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ready; accept a request, decode exceptions on the spot
//   ST_REQ  | mem_req asserted, waiting for mem_gnt (or timeout)
//   ST_WAIT | granted, waiting for mem_rvalid (or timeout)
//   ST_RESP | rsp_valid pulse for one cycle
module lsu
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);

  // Expiry is checked against the cycle count minus one so that mem_req is
  // seen for exactly TIMEOUT cycles before the fault response.
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

  lsu_state_t state, next_state;

  logic        is_load_in, is_store_in, illegal_in, misalign_in, exc_in;
  logic [3:0]  cause_in;

  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [31:0] cnt;
  logic        expire;
  logic [3:0]  fault_cause;

  logic [2:0]  a_funct3;
  logic [1:0]  a_off;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_rdata;

  logic        mem_req_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_be_d;
  logic        rsp_valid_d, rsp_we_d, rsp_exc_d;
  logic [4:0]  rsp_rd_d;
  logic [31:0] rsp_data_d;
  logic [3:0]  rsp_cause_d;

  assign is_load_in  = (bus.req_opcode == OPC_LOAD);
  assign is_store_in = (bus.req_opcode == OPC_STORE);
  assign illegal_in  = !(is_load_in || is_store_in)
                     || (is_load_in  && ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11)))
                     || (is_store_in && (bus.req_funct3 >= 3'b011));
  assign misalign_in = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
                     || ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign exc_in      = illegal_in || misalign_in;
  assign cause_in    = illegal_in ? CAUSE_ILLEGAL :
                       is_load_in ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;

  assign expire      = TO_EN && (cnt >= TO_LAST);
  assign fault_cause = is_load_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
  assign bus.req_ready = (state == ST_IDLE);

  // Lanes come from the live request while idle (to register the bus
  // outputs at accept) and from the latched fields afterwards.
  assign a_funct3 = (state == ST_IDLE) ? bus.req_funct3 : funct3_q;
  assign a_off    = (state == ST_IDLE) ? bus.req_addr[1:0] : off_q;

  lsu_align u_align (
    .funct3    (a_funct3),
    .offset    (a_off),
    .wdata_in  (bus.req_wdata),
    .rdata     (bus.mem_rdata),
    .be        (a_be),
    .wdata_rep (a_wdata),
    .rdata_ext (a_rdata)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // next-state decode; grant and rvalid take priority over expiry
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.req_valid) next_state = exc_in ? ST_RESP : ST_REQ;
      ST_REQ:  if (bus.mem_gnt) next_state = ST_WAIT;
               else if (expire) next_state = ST_RESP;
      ST_WAIT: if (bus.mem_rvalid || expire) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // next values of the registered bus and response outputs
  always_comb begin
    mem_req_d   = bus.mem_req;
    mem_we_d    = bus.mem_we;
    mem_addr_d  = bus.mem_addr;
    mem_be_d    = bus.mem_be;
    mem_wdata_d = bus.mem_wdata;
    rsp_valid_d = 1'b0;
    rsp_we_d    = 1'b0;
    rsp_rd_d    = 5'd0;
    rsp_data_d  = 32'd0;
    rsp_exc_d   = 1'b0;
    rsp_cause_d = 4'd0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (exc_in) begin
            rsp_valid_d = 1'b1;
            rsp_exc_d   = 1'b1;
            rsp_cause_d = cause_in;
            rsp_rd_d    = bus.req_rd;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_in;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_be_d    = a_be;
            mem_wdata_d = is_store_in ? a_wdata : 32'd0;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt || expire) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_be_d    = 4'd0;
          mem_wdata_d = 32'd0;
        end
        if (!bus.mem_gnt && expire) begin
          rsp_valid_d = 1'b1;
          rsp_exc_d   = 1'b1;
          rsp_cause_d = fault_cause;
          rsp_rd_d    = rd_q;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid || expire) begin
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          if (!bus.mem_rvalid || bus.mem_err) begin
            rsp_exc_d   = 1'b1;
            rsp_cause_d = fault_cause;
          end else if (is_load_q) begin
            rsp_data_d = a_rdata;
            rsp_we_d   = (rd_q != 5'd0);
          end
        end
      end
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_be    <= 4'd0;
      bus.mem_wdata <= 32'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_we    <= 1'b0;
      bus.rsp_rd    <= 5'd0;
      bus.rsp_data  <= 32'd0;
      bus.rsp_exc   <= 1'b0;
      bus.rsp_cause <= 4'd0;
    end else begin
      bus.mem_req   <= mem_req_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_be    <= mem_be_d;
      bus.mem_wdata <= mem_wdata_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_we    <= rsp_we_d;
      bus.rsp_rd    <= rsp_rd_d;
      bus.rsp_data  <= rsp_data_d;
      bus.rsp_exc   <= rsp_exc_d;
      bus.rsp_cause <= rsp_cause_d;
    end
  end

  // latch the request fields needed after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load_q <= 1'b0;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      rd_q      <= 5'd0;
    end else if (state == ST_IDLE && bus.req_valid) begin
      is_load_q <= is_load_in;
      funct3_q  <= bus.req_funct3;
      off_q     <= bus.req_addr[1:0];
      rd_q      <= bus.req_rd;
    end
  end

  // timeout counter: cleared on entry to REQ, counts through REQ and WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          cnt <= 32'd0;
    else if (state == ST_IDLE && next_state == ST_REQ)   cnt <= 32'd0;
    else if (state == ST_REQ || state == ST_WAIT)        cnt <= cnt + 32'd1;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the LSU with TIMEOUT=8. Inputs are driven and outputs
// sampled on the falling clock edge; cycle 0 is the accept cycle.
module tb_lsu;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  lsu_if bus ();

  lsu #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // present a request for one cycle; returns at the falling edge of cycle 1
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  // best-case transaction (gnt cycle 1, rvalid cycle 2); captures bus outputs
  // in cycle 1 and response outputs in cycle 3, returns in cycle 4
  task automatic bus_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic err,
                         output logic m_req, output logic m_we, output logic [31:0] m_addr,
                         output logic [3:0] m_be, output logic [31:0] m_wdata,
                         output logic r_valid, output logic r_we, output logic r_exc,
                         output logic [31:0] r_data, output logic [3:0] r_cause,
                         output logic [4:0] r_rd);
    issue(op, f3, a, wd, rd);
    m_req = bus.mem_req; m_we = bus.mem_we; m_addr = bus.mem_addr;
    m_be = bus.mem_be; m_wdata = bus.mem_wdata;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata; bus.mem_err = err;
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
    r_valid = bus.rsp_valid; r_we = bus.rsp_we; r_exc = bus.rsp_exc;
    r_data = bus.rsp_data; r_cause = bus.rsp_cause; r_rd = bus.rsp_rd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.req_ready); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", bus.mem_req); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
    total++; if ({bus.mem_be, bus.rsp_cause, bus.mem_addr} !== 40'd0) begin bad++; $display("FAIL rst_outputs got=%h want=0", {bus.mem_be, bus.rsp_cause, bus.mem_addr}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    issue(OPC_STORE, F3_SW, 32'h0000_1000, 32'hDEAD_BEEF, 5'd0);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL sw_req_c1 got=%b want=1", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%b want=1", bus.mem_we); end
    total++; if (bus.mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL sw_addr got=%h want=00001000", bus.mem_addr); end
    total++; if (bus.mem_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b want=1111", bus.mem_be); end
    total++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata got=%h want=deadbeef", bus.mem_wdata); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL sw_busy got=%b want=0", bus.req_ready); end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL sw_req_drop got=%b want=0", bus.mem_req); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL sw_rsp_early got=%b want=0", bus.rsp_valid); end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL sw_rsp_c3 got=%b want=1", bus.rsp_valid); end
    total++; if ({bus.rsp_we, bus.rsp_exc} !== 2'b00) begin bad++; $display("FAIL sw_rsp_flags got=%b want=00", {bus.rsp_we, bus.rsp_exc}); end
    total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL sw_rsp_data got=%h want=0", bus.rsp_data); end
    @(negedge clk);
    total++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin bad++; $display("FAIL sw_c4 valid_ready got=%b want=01", {bus.rsp_valid, bus.req_ready}); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5]  = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
    logic [31:0] ad [5]  = '{32'h2003, 32'h2003, 32'h2002, 32'h2000, 32'h2000};
    logic [3:0]  be [5]  = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1111};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234, 32'h80FF_1234};
    logic m_req, m_we, r_valid, r_we, r_exc;
    logic [31:0] m_addr, m_wdata, r_data;
    logic [3:0] m_be, r_cause;
    logic [4:0] r_rd;
    for (int i = 0; i < 5; i++) begin
      bus_txn(OPC_LOAD, f3[i], ad[i], 32'hFFFF_FFFF, 5'd5, 32'h80FF_1234, 1'b0,
              m_req, m_we, m_addr, m_be, m_wdata, r_valid, r_we, r_exc, r_data, r_cause, r_rd);
      total++; if ({m_req, m_we} !== 2'b10) begin bad++; $display("FAIL ld%0d req_we got=%b want=10", i, {m_req, m_we}); end
      total++; if (m_addr !== 32'h2000 || m_wdata !== 32'd0) begin bad++; $display("FAIL ld%0d addr_wdata got=%h/%h want=00002000/0", i, m_addr, m_wdata); end
      total++; if (m_be !== be[i]) begin bad++; $display("FAIL ld%0d be got=%b want=%b", i, m_be, be[i]); end
      total++; if (r_data !== exp[i]) begin bad++; $display("FAIL ld%0d data got=%h want=%h", i, r_data, exp[i]); end
      total++; if ({r_valid, r_we, r_exc, r_rd} !== {3'b110, 5'd5}) begin bad++; $display("FAIL ld%0d rsp got=%b want=11000101", i, {r_valid, r_we, r_exc, r_rd}); end
    end
  endtask

  task automatic test_store_lanes();
    logic m_req, m_we, r_valid, r_we, r_exc;
    logic [31:0] m_addr, m_wdata, r_data;
    logic [3:0] m_be, r_cause;
    logic [4:0] r_rd;
    bus_txn(OPC_STORE, F3_SH, 32'h3002, 32'h0000_ABCD, 5'd0, 32'd0, 1'b0,
            m_req, m_we, m_addr, m_be, m_wdata, r_valid, r_we, r_exc, r_data, r_cause, r_rd);
    total++; if (m_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b want=1100", m_be); end
    total++; if (m_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got=%h want=abcdabcd", m_wdata); end
    total++; if (m_addr !== 32'h3000) begin bad++; $display("FAIL sh_addr got=%h want=00003000", m_addr); end
    total++; if ({r_valid, r_we, r_exc} !== 3'b100) begin bad++; $display("FAIL sh_rsp got=%b want=100", {r_valid, r_we, r_exc}); end
    bus_txn(OPC_STORE, F3_SB, 32'h4001, 32'h1234_565A, 5'd0, 32'd0, 1'b0,
            m_req, m_we, m_addr, m_be, m_wdata, r_valid, r_we, r_exc, r_data, r_cause, r_rd);
    total++; if (m_be !== 4'b0010) begin bad++; $display("FAIL sb_be got=%b want=0010", m_be); end
    total++; if (m_wdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL sb_wdata got=%h want=5a5a5a5a", m_wdata); end
  endtask

  task automatic test_exceptions();
    logic [6:0]  op [5]  = '{OPC_LOAD, OPC_STORE, OPC_LOAD, OPC_STORE, 7'b0110011};
    logic [2:0]  f3 [5]  = '{F3_LW, F3_SH, 3'b011, 3'b011, 3'b000};
    logic [31:0] ad [5]  = '{32'h3002, 32'h1001, 32'h1000, 32'h1000, 32'h1000};
    logic [3:0]  cs [5]  = '{4'd4, 4'd6, 4'd2, 4'd2, 4'd2};
    for (int i = 0; i < 5; i++) begin
      issue(op[i], f3[i], ad[i], 32'h1111_2222, 5'd9);
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL exc%0d mem_req got=%b want=0", i, bus.mem_req); end
      total++; if ({bus.rsp_valid, bus.rsp_exc, bus.rsp_we} !== 3'b110) begin bad++; $display("FAIL exc%0d rsp got=%b want=110", i, {bus.rsp_valid, bus.rsp_exc, bus.rsp_we}); end
      total++; if (bus.rsp_cause !== cs[i]) begin bad++; $display("FAIL exc%0d cause got=%0d want=%0d", i, bus.rsp_cause, cs[i]); end
      total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL exc%0d data got=%h want=0", i, bus.rsp_data); end
      @(negedge clk);
      total++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin bad++; $display("FAIL exc%0d c2 ready_valid got=%b want=10", i, {bus.req_ready, bus.rsp_valid}); end
    end
  endtask

  task automatic test_timeout();
    issue(OPC_LOAD, F3_LW, 32'h5000, 32'd0, 5'd3);
    for (int c = 1; c <= 8; c++) begin
      total++; if ({bus.mem_req, bus.rsp_valid} !== 2'b10) begin bad++; $display("FAIL to_c%0d req_valid got=%b want=10", c, {bus.mem_req, bus.rsp_valid}); end
      @(negedge clk);
    end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b want=0", bus.mem_req); end
    total++; if ({bus.rsp_valid, bus.rsp_exc, bus.rsp_we} !== 3'b110) begin bad++; $display("FAIL to_rsp got=%b want=110", {bus.rsp_valid, bus.rsp_exc, bus.rsp_we}); end
    total++; if (bus.rsp_cause !== 4'd5) begin bad++; $display("FAIL to_cause got=%0d want=5", bus.rsp_cause); end
    bus.mem_rvalid = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    total++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin bad++; $display("FAIL to_late_c10 got=%b want=01", {bus.rsp_valid, bus.req_ready}); end
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
    total++; if ({bus.rsp_valid, bus.mem_req, bus.req_ready} !== 3'b001) begin bad++; $display("FAIL to_late_c11 got=%b want=001", {bus.rsp_valid, bus.mem_req, bus.req_ready}); end

    // grant arrives in the expiry cycle: grant wins
    issue(OPC_LOAD, F3_LW, 32'h5004, 32'd0, 5'd4);
    repeat (7) @(negedge clk);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL gw_req_c8 got=%b want=1", bus.mem_req); end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    total++; if ({bus.rsp_valid, bus.mem_req} !== 2'b00) begin bad++; $display("FAIL gw_c9 got=%b want=00", {bus.rsp_valid, bus.mem_req}); end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    total++; if ({bus.rsp_valid, bus.rsp_exc, bus.rsp_we} !== 3'b101) begin bad++; $display("FAIL gw_rsp got=%b want=101", {bus.rsp_valid, bus.rsp_exc, bus.rsp_we}); end
    total++; if (bus.rsp_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL gw_data got=%h want=cafef00d", bus.rsp_data); end
    @(negedge clk);

    // rvalid arrives in the expiry cycle: rvalid wins
    issue(OPC_LOAD, F3_LW, 32'h5008, 32'd0, 5'd6);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rw_c8 got=%b want=0", bus.rsp_valid); end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1122_3344;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    total++; if ({bus.rsp_valid, bus.rsp_exc, bus.rsp_we} !== 3'b101) begin bad++; $display("FAIL rw_rsp got=%b want=101", {bus.rsp_valid, bus.rsp_exc, bus.rsp_we}); end
    total++; if (bus.rsp_data !== 32'h1122_3344) begin bad++; $display("FAIL rw_data got=%h want=11223344", bus.rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_bus_error();
    logic m_req, m_we, r_valid, r_we, r_exc;
    logic [31:0] m_addr, m_wdata, r_data;
    logic [3:0] m_be, r_cause;
    logic [4:0] r_rd;
    bus_txn(OPC_LOAD, F3_LW, 32'h7000, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b1,
            m_req, m_we, m_addr, m_be, m_wdata, r_valid, r_we, r_exc, r_data, r_cause, r_rd);
    total++; if ({r_valid, r_exc, r_we} !== 3'b110) begin bad++; $display("FAIL lerr_rsp got=%b want=110", {r_valid, r_exc, r_we}); end
    total++; if (r_cause !== 4'd5 || r_data !== 32'd0) begin bad++; $display("FAIL lerr_cause_data got=%0d/%h want=5/0", r_cause, r_data); end
    bus_txn(OPC_STORE, F3_SW, 32'h7004, 32'h1357_9BDF, 5'd0, 32'd0, 1'b1,
            m_req, m_we, m_addr, m_be, m_wdata, r_valid, r_we, r_exc, r_data, r_cause, r_rd);
    total++; if ({r_valid, r_exc, r_we} !== 3'b110) begin bad++; $display("FAIL serr_rsp got=%b want=110", {r_valid, r_exc, r_we}); end
    total++; if (r_cause !== 4'd7) begin bad++; $display("FAIL serr_cause got=%0d want=7", r_cause); end
  endtask

  task automatic test_reset_mid();
    logic m_req, m_we, r_valid, r_we, r_exc;
    logic [31:0] m_addr, m_wdata, r_data;
    logic [3:0] m_be, r_cause;
    logic [4:0] r_rd;
    // reset while requesting: mem_req drops at once
    issue(OPC_LOAD, F3_LW, 32'h6000, 32'd0, 5'd7);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rstq_req_before got=%b want=1", bus.mem_req); end
    rst_n = 1'b0;
    #1;
    total++; if ({bus.mem_req, bus.req_ready} !== 2'b01) begin bad++; $display("FAIL rstq_req_drop got=%b want=01", {bus.mem_req, bus.req_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // reset while waiting for rvalid; a late rvalid must not produce a response
    issue(OPC_LOAD, F3_LW, 32'h6000, 32'd0, 5'd7);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.mem_req, bus.rsp_valid, bus.req_ready} !== 3'b001) begin bad++; $display("FAIL rstw_now got=%b want=001", {bus.mem_req, bus.rsp_valid, bus.req_ready}); end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rstw_late_rvalid got=%b want=0", bus.rsp_valid); end
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    bus_txn(OPC_LOAD, F3_LW, 32'h6010, 32'd0, 5'd0, 32'h1234_5678, 1'b0,
            m_req, m_we, m_addr, m_be, m_wdata, r_valid, r_we, r_exc, r_data, r_cause, r_rd);
    total++; if ({m_req, r_valid, r_exc, r_we} !== 4'b1100) begin bad++; $display("FAIL rst_rd0 got=%b want=1100", {m_req, r_valid, r_exc, r_we}); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_opcode = 7'd0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0; bus.mem_err = 1'b0;
    test_reset();
    test_store_word();
    test_loads();
    test_store_lanes();
    test_exceptions();
    test_timeout();
    test_bus_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
